// File: rtl/uart_arb_pkg.sv
// Shared types and the round-robin search used by the UART TX arbiter
// and its picker sub-module.
package uart_arb_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} arb_state_e;

  localparam int MAX_REQ = 8;

  // First set bit of valid strictly after last (mod n), wrapping around.
  // Returns 0 when nothing is valid; callers qualify with |valid.
  function automatic logic [2:0] rr_next(input logic [2:0] last,
                                         input logic [MAX_REQ-1:0] valid,
                                         input int n);
    logic [2:0] hi, lo;
    logic       hi_found, lo_found;
    hi = '0; lo = '0; hi_found = 1'b0; lo_found = 1'b0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n && valid[i]) begin
        if (i > int'(last)) begin
          hi = 3'(i); hi_found = 1'b1;
        end else begin
          lo = 3'(i); lo_found = 1'b1;
        end
      end
    end
    return hi_found ? hi : (lo_found ? lo : 3'd0);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: first valid requester after
// last_grant, as both a one-hot vector and an index.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index
);

  logic [2:0] idx3;

  always_comb begin
    idx3  = rr_next(3'(last_grant), 8'(valid), N);
    index = IW'(idx3);
    for (int i = 0; i < N; i++) onehot[i] = (|valid) && (idx3 == 3'(i));
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// producers. Define UART_ARB_LOCK_EN to add req_last multi-byte locking.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_last,
`endif
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       start_tx,
  input  logic                       tx_done,
  input  logic                       cts_n,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int IW      = $clog2(NUM_REQ);
  localparam int TIMER_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TIMER_W-1:0] TMO_LAST =
    TIMER_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  arb_state_e         state_q, state_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [IW-1:0]      grant_id_q, grant_id_d;
  logic [IW-1:0]      last_grant_q, last_grant_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               start_tx_q, start_tx_d;
  logic               busy_q, busy_d;
  logic               timeout_err_q, timeout_err_d;
  logic               tx_done_q, tx_done_d;

  logic [NUM_REQ-1:0] valid_eff, pick_oh;
  logic [IW-1:0]      pick_idx;
  logic [7:0]         pick_byte;
  logic               xfer, done_edge;

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d, lastb_q, lastb_d;

  // While locked only the owner of the last frame may be picked.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      valid_eff[i] = req_valid[i] && (!lock_q || grant_id_q == IW'(i));
  end
`else
  assign valid_eff = req_valid;
`endif

  uart_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .valid      (valid_eff),
    .last_grant (last_grant_q),
    .onehot     (pick_oh),
    .index      (pick_idx)
  );

  assign req_ready = (reset_n && state_q == IDLE && !cts_n) ? pick_oh : '0;
  assign xfer      = |(req_valid & req_ready);
  // Only a fresh rising edge ends a frame; a level left high is ignored.
  assign done_edge = tx_done && !tx_done_q;
  assign tx_done_d = tx_done;

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_oh[i]) pick_byte = req_data[i*8 +: 8];
  end

  always_comb begin
    state_d       = state_q;
    tx_data_d     = tx_data_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    timer_d       = timer_q;
    start_tx_d    = 1'b0;
    timeout_err_d = 1'b0;
`ifdef UART_ARB_LOCK_EN
    lock_d        = lock_q;
    lastb_d       = lastb_q;
`endif
    case (state_q)
      IDLE: if (xfer) begin
        tx_data_d  = pick_byte;
        grant_id_d = pick_idx;
        start_tx_d = 1'b1;
        state_d    = LAUNCH;
`ifdef UART_ARB_LOCK_EN
        lastb_d    = |(req_last & pick_oh);
`endif
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TIMER_W'(1);
        if (done_edge) begin
          last_grant_d = grant_id_q;
          state_d      = IDLE;
`ifdef UART_ARB_LOCK_EN
          lock_d       = !lastb_q;
`endif
        end else if (TIMEOUT_CYC != 0 && timer_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
          last_grant_d  = grant_id_q;
          state_d       = IDLE;
`ifdef UART_ARB_LOCK_EN
          lock_d        = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      last_grant_q  <= IW'(NUM_REQ - 1);
      timer_q       <= '0;
      start_tx_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      tx_done_q     <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_q        <= 1'b0;
      lastb_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      timer_q       <= timer_d;
      start_tx_q    <= start_tx_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      tx_done_q     <= tx_done_d;
`ifdef UART_ARB_LOCK_EN
      lock_q        <= lock_d;
      lastb_q       <= lastb_d;
`endif
    end
  end

  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign start_tx    = start_tx_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 16-cycle
// timeout); the lock scenario is built when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        start_tx;
  logic        tx_done;
  logic        cts_n;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;
`ifdef UART_ARB_LOCK_EN
  logic [3:0]  req_last;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
`ifdef UART_ARB_LOCK_EN
    .req_last    (req_last),
`endif
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .start_tx    (start_tx),
    .tx_done     (tx_done),
    .cts_n       (cts_n),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; req_valid = '0; tx_done = 1'b0; cts_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // Ends a frame that has just been launched: one WAIT cycle, then a done edge.
  task automatic finish_frame();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 4'hF; req_data = '0; cts_n = 1'b0; tx_done = 1'b0;
    tick();
    chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL rst_ready: got %b exp 0000", req_ready); else pass_cnt++;
    chk_cnt++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h exp 00", tx_data); else pass_cnt++;
    chk_cnt++; if ({start_tx, busy, timeout_err} !== 3'b000) $display("FAIL rst_flags: got %b exp 000", {start_tx, busy, timeout_err}); else pass_cnt++;
    chk_cnt++; if (grant_id !== 2'd0) $display("FAIL rst_grant: got %0d exp 0", grant_id); else pass_cnt++;
    reset_n = 1'b1;
    #1;
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL rst_first_prio: got %b exp 0001", req_ready); else pass_cnt++;
    req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    req_data = 32'h0000_00A5; req_valid = 4'b0001;
    #1;
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b exp 0001", req_ready); else pass_cnt++;
    tick();
    req_valid = '0;
    chk_cnt++; if ({start_tx, busy} !== 2'b11) $display("FAIL single_launch: got %b exp 11", {start_tx, busy}); else pass_cnt++;
    chk_cnt++; if (tx_data !== 8'hA5) $display("FAIL single_data: got %h exp a5", tx_data); else pass_cnt++;
    tick();
    chk_cnt++; if ({start_tx, busy} !== 2'b01) $display("FAIL single_wait: got %b exp 01", {start_tx, busy}); else pass_cnt++;
    tick(); tick();
    chk_cnt++; if (busy !== 1'b1) $display("FAIL single_busy_hold: got %b exp 1", busy); else pass_cnt++;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL single_done: got %b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_fairness();
    apply_reset();
    req_data = 32'h1312_1110; req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] eg;
      logic [3:0] eoh;
      logic [7:0] ed;
      eg  = 2'(k % 4);
      eoh = 4'b0001 << eg;
      ed  = 8'h10 + 8'(eg);
      #1;
      chk_cnt++; if (req_ready !== eoh) $display("FAIL fair_ready[%0d]: got %b exp %b", k, req_ready, eoh); else pass_cnt++;
      tick();
      chk_cnt++; if ({start_tx, grant_id, tx_data} !== {1'b1, eg, ed}) $display("FAIL fair_launch[%0d]: got %b/%0d/%h exp 1/%0d/%h", k, start_tx, grant_id, tx_data, eg, ed); else pass_cnt++;
      tick();
      chk_cnt++; if (start_tx !== 1'b0) $display("FAIL fair_one_start[%0d]: got %b exp 0", k, start_tx); else pass_cnt++;
      finish_frame();
    end
    req_valid = '0;
  endtask

  task automatic test_flow_control();
    int seen;
    seen = 0;
    req_data = 32'h00C3_0000; cts_n = 1'b1; req_valid = 4'b0100;
    repeat (50) begin
      #1;
      if (req_ready !== 4'b0000 || busy !== 1'b0) seen++;
      tick();
    end
    chk_cnt++; if (seen !== 0) $display("FAIL cts_block: got %0d ready cycles exp 0", seen); else pass_cnt++;
    cts_n = 1'b0;
    #1;
    chk_cnt++; if (req_ready !== 4'b0100) $display("FAIL cts_release: got %b exp 0100", req_ready); else pass_cnt++;
    tick();
    req_valid = '0;
    chk_cnt++; if ({start_tx, grant_id, tx_data} !== {1'b1, 2'd2, 8'hC3}) $display("FAIL cts_launch: got %b/%0d/%h exp 1/2/c3", start_tx, grant_id, tx_data); else pass_cnt++;
    tick();
    cts_n = 1'b1;
    tick(); tick();
    chk_cnt++; if (busy !== 1'b1) $display("FAIL cts_mid_frame: got %b exp 1", busy); else pass_cnt++;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL cts_completes: got %b exp 0", busy); else pass_cnt++;
    cts_n = 1'b0;
  endtask

  task automatic test_stale_done();
    req_data = 32'h0000_5A00; tx_done = 1'b1;
    tick();
    req_valid = 4'b0010;
    #1;
    chk_cnt++; if (req_ready !== 4'b0010) $display("FAIL stale_ready: got %b exp 0010", req_ready); else pass_cnt++;
    tick();
    req_valid = '0;
    chk_cnt++; if ({start_tx, tx_data} !== {1'b1, 8'h5A}) $display("FAIL stale_launch: got %b/%h exp 1/5a", start_tx, tx_data); else pass_cnt++;
    tick(); tick(); tick();
    chk_cnt++; if (busy !== 1'b1) $display("FAIL stale_level_ignored: got %b exp 1", busy); else pass_cnt++;
    tx_done = 1'b0;
    tick();
    chk_cnt++; if (busy !== 1'b1) $display("FAIL stale_fall: got %b exp 1", busy); else pass_cnt++;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL stale_new_edge: got %b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    apply_reset();
    req_data = 32'h0000_6677; req_valid = 4'b0011;
    #1;
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL tmo_ready: got %b exp 0001", req_ready); else pass_cnt++;
    tick();
    tick();
    repeat (15) begin
      tick();
      if (timeout_err !== 1'b0 || busy !== 1'b1) early++;
    end
    chk_cnt++; if (early !== 0) $display("FAIL tmo_early: got %0d bad cycles exp 0", early); else pass_cnt++;
    tick();
    chk_cnt++; if ({timeout_err, busy} !== 2'b10) $display("FAIL tmo_pulse: got %b exp 10", {timeout_err, busy}); else pass_cnt++;
    #1;
    chk_cnt++; if (req_ready !== 4'b0010) $display("FAIL tmo_skip: got %b exp 0010", req_ready); else pass_cnt++;
    tick();
    req_valid = '0;
    chk_cnt++; if (timeout_err !== 1'b0) $display("FAIL tmo_one_cycle: got %b exp 0", timeout_err); else pass_cnt++;
    chk_cnt++; if ({start_tx, grant_id, tx_data} !== {1'b1, 2'd1, 8'h66}) $display("FAIL tmo_next: got %b/%0d/%h exp 1/1/66", start_tx, grant_id, tx_data); else pass_cnt++;
    finish_frame();
    chk_cnt++; if (busy !== 1'b0) $display("FAIL tmo_after: got %b exp 0", busy); else pass_cnt++;
  endtask

`ifdef UART_ARB_LOCK_EN
  task automatic test_lock();
    apply_reset();
    req_data = 32'h4433_2211; req_last = 4'b0000; req_valid = 4'b0100;
    #1;
    tick();
    finish_frame();
    req_valid = 4'hF; req_last = 4'b0100;
    #1;
    chk_cnt++; if (req_ready !== 4'b0100) $display("FAIL lock_hold: got %b exp 0100", req_ready); else pass_cnt++;
    tick();
    finish_frame();
    #1;
    chk_cnt++; if (req_ready !== 4'b1000) $display("FAIL lock_release: got %b exp 1000", req_ready); else pass_cnt++;
    req_valid = 4'b0100; req_last = 4'b0000;
    #1;
    chk_cnt++; if (req_ready !== 4'b0100) $display("FAIL lock_relock: got %b exp 0100", req_ready); else pass_cnt++;
    tick();
    finish_frame();
    req_valid = 4'b1011;
    #1;
    chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL lock_stall: got %b exp 0000", req_ready); else pass_cnt++;
    req_valid = '0;
    tick();
  endtask
`endif

  task automatic test_reset_in_wait();
    req_data = 32'h0099_0000; req_valid = 4'b0100;
`ifdef UART_ARB_LOCK_EN
    req_last = 4'b0000;
`endif
    #1;
    tick();
    req_valid = '0;
    tick(); tick();
    chk_cnt++; if ({busy, grant_id, tx_data} !== {1'b1, 2'd2, 8'h99}) $display("FAIL rwait_pre: got %b/%0d/%h exp 1/2/99", busy, grant_id, tx_data); else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    chk_cnt++; if ({busy, start_tx, timeout_err, grant_id, tx_data} !== 13'd0) $display("FAIL rwait_clear: got %b/%b/%b/%0d/%h exp all 0", busy, start_tx, timeout_err, grant_id, tx_data); else pass_cnt++;
    tick();
    reset_n = 1'b1; req_valid = 4'hF;
    #1;
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL rwait_prio: got %b exp 0001", req_ready); else pass_cnt++;
    req_valid = '0;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; req_valid = '0; req_data = '0; tx_done = 1'b0; cts_n = 1'b0;
`ifdef UART_ARB_LOCK_EN
    req_last = 4'hF;
`endif
    test_reset();
    test_single();
    test_fairness();
    test_flow_control();
    test_stale_done();
    test_timeout();
`ifdef UART_ARB_LOCK_EN
    test_lock();
`endif
    test_reset_in_wait();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
